// File: rtl/nco_pkg.sv
// Shared definitions for the phase-accumulator NCO: opcodes, FSM states, default widths.
package nco_pkg;

    localparam int unsigned ACC_W_DEF   = 24;
    localparam int unsigned PHASE_W_DEF = 8;

    // Command opcodes carried on cmd_op
    localparam logic [2:0] OP_SET_FTW    = 3'b000;
    localparam logic [2:0] OP_SET_OFFSET = 3'b001;
    localparam logic [2:0] OP_SET_STEP   = 3'b010;
    localparam logic [2:0] OP_SET_LIMIT  = 3'b011;
    localparam logic [2:0] OP_START      = 3'b100;
    localparam logic [2:0] OP_STOP       = 3'b101;
    localparam logic [2:0] OP_CLR_PHASE  = 3'b110;
    localparam logic [2:0] OP_RSVD       = 3'b111;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } nco_state_e;

endpackage

// File: rtl/nco_cmd_if.sv
// Valid/ready command port of the NCO: opcode plus one ACC_W-bit operand.
interface nco_cmd_if #(
    parameter int unsigned ACC_W = 24
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [ACC_W-1:0] cmd_data;

    // Command source (pins / testbench)
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    // Command sink (the NCO)
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/nco_sweep_ctrl.sv
// Chirp controller: next FTW after one sweep step, clamped to the configured limit.
// Purely combinational; the top decides when the result is committed.
module nco_sweep_ctrl #(
    parameter int unsigned ACC_W = 24
) (
    input  logic [ACC_W-1:0] ftw,
    input  logic [ACC_W-1:0] step,       // two's complement
    input  logic [ACC_W-1:0] limit,      // unsigned
    input  logic             carry,      // accumulator overflowed this cycle
    input  logic             enable,     // running, step != 0, sweep not yet done
    output logic [ACC_W-1:0] ftw_next,
    output logic             clamp_hit
);

    logic             step_neg;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sum_lo;
    logic             out_of_range;
    logic             past_limit;
    logic             update;

    // Sweep arithmetic, clamp decision and FTW selection
    always_comb begin
        step_neg = step[ACC_W-1];
        // Zero-extended ftw plus sign-extended step. With the step sign known, bit ACC_W
        // flags overflow (positive step) or underflow (negative step) alike.
        sum          = {1'b0, ftw} + {step[ACC_W-1], step};
        sum_lo       = sum[ACC_W-1:0];
        out_of_range = sum[ACC_W];
        // Landing exactly on the limit also counts as reaching it, so the sweep ends there
        past_limit   = step_neg ? (sum_lo <= limit) : (sum_lo >= limit);

        update    = enable & carry;
        clamp_hit = update & (out_of_range | past_limit);

        ftw_next = ftw;
        if (update) begin
            ftw_next = clamp_hit ? limit : sum_lo;
        end
    end

endmodule

// File: rtl/phase_accum_nco.sv
// Numerically controlled phase generator feeding sine_lookup. Accumulates the FTW each
// cycle while running and emits the top PHASE_W accumulator bits plus an offset. An
// optional linear FTW sweep (chirp) is applied once per accumulator wrap.
module phase_accum_nco
    import nco_pkg::*;
#(
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    nco_cmd_if.slave           cmd,
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_vld,
    output logic               wrap,
    output logic               sweep_done
);

    nco_state_e state_q, state_d;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ftw_q, ftw_d;
    logic [ACC_W-1:0]   step_q, step_d;
    logic [ACC_W-1:0]   limit_q, limit_d;
    logic [PHASE_W-1:0] offset_q, offset_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               vld_q;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               ready_en_q;

    logic [ACC_W:0]     acc_sum;
    logic               carry;
    logic               running;
    logic               sweep_en;
    logic               sweep_commit;
    logic [ACC_W-1:0]   sweep_ftw;
    logic               clamp_hit;
    logic               cmd_fire;

    // Accumulator add, sweep qualification and command handshake
    always_comb begin
        acc_sum  = {1'b0, acc_q} + {1'b0, ftw_q};
        running  = (state_q == StRun);
        carry    = running & acc_sum[ACC_W];
        sweep_en = running & ~done_q & (step_q != '0);
        // A sweep update owns the FTW register this cycle, so commands are held off
        sweep_commit  = sweep_en & carry;
        cmd.cmd_ready = ready_en_q & ~sweep_commit;
        cmd_fire      = cmd.cmd_valid & cmd.cmd_ready;
    end

    nco_sweep_ctrl #(
        .ACC_W (ACC_W)
    ) u_sweep (
        .ftw       (ftw_q),
        .step      (step_q),
        .limit     (limit_q),
        .carry     (carry),
        .enable    (sweep_en),
        .ftw_next  (sweep_ftw),
        .clamp_hit (clamp_hit)
    );

    // FSM next state: only START and STOP move it
    always_comb begin
        state_d = state_q;
        if (cmd_fire) begin
            unique case (cmd.cmd_op)
                OP_START: state_d = StRun;
                OP_STOP:  state_d = StIdle;
                default:  state_d = state_q;
            endcase
        end
    end

    // Datapath next state: accumulate, sweep, then apply any accepted command
    always_comb begin
        acc_d    = running ? acc_sum[ACC_W-1:0] : acc_q;
        wrap_d   = carry;
        ftw_d    = sweep_ftw;
        done_d   = done_q | clamp_hit;
        step_d   = step_q;
        limit_d  = limit_q;
        offset_d = offset_q;
        // Phase is taken from the registered accumulator, hence one cycle behind it
        phase_d  = acc_q[ACC_W-1 -: PHASE_W] + offset_q;

        if (cmd_fire) begin
            unique case (cmd.cmd_op)
                OP_SET_FTW:    ftw_d    = cmd.cmd_data;
                OP_SET_OFFSET: offset_d = cmd.cmd_data[PHASE_W-1:0];
                OP_SET_STEP:   step_d   = cmd.cmd_data;
                OP_SET_LIMIT:  limit_d  = cmd.cmd_data;
                OP_START:      done_d   = 1'b0;
                OP_STOP: begin
                    acc_d  = '0;
                    done_d = 1'b0;
                end
                // Clearing the phase leaves the wrap pulse and sweep update of this cycle
                OP_CLR_PHASE:  acc_d    = '0;
                default:       ;
            endcase
        end
    end

    // State registers with synchronous reset; any in-flight command is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            ftw_q      <= '0;
            step_q     <= '0;
            limit_q    <= '1;
            offset_q   <= '0;
            phase_q    <= '0;
            vld_q      <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ftw_q      <= ftw_d;
            step_q     <= step_d;
            limit_q    <= limit_d;
            offset_q   <= offset_d;
            phase_q    <= phase_d;
            vld_q      <= running;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
            ready_en_q <= 1'b1;
        end
    end

    // Output mapping
    always_comb begin
        phase_out  = phase_q;
        phase_vld  = vld_q;
        wrap       = wrap_q;
        sweep_done = done_q;
    end

endmodule
